mips_bus_master: RTL and testbench
==================================

# mips_bus_master

Parametrised Avalon-MM bus master sitting between the multi-cycle MIPS core (state/control logic) and the external memory bus. Accepts one load or store request at a time from the core, generates aligned bus address, byteenable and lane-shifted writedata, and handles waitrequest stalls. Returns zero- or sign-extended read data with a one-cycle response pulse. Generalises the fixed 32-bit bus port to 32- or 64-bit data, with sub-word sizing, misalignment detection and an optional stall timeout.

## Interface
- ADDR_W, 32, byte-address width.
- DATA_W, 32, bus data width; legal values 32 or 64. BE_W = DATA_W/8.
- TIMEOUT_CYCLES, 255, waitrequest stall limit; used only with the timeout feature.

- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  1  core request present.
- req_ready  out  1  high only in IDLE; a request is accepted on an edge where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when DATA_W=64).
- req_signed  in  1  sign-extend load data (ignored for stores).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse: request complete.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  valid with rsp_valid: misaligned, illegal size or timeout.
- busy  out  1  high in any state other than IDLE.
- address  out  ADDR_W  bus address, low log2(BE_W) bits always 0.
- read, write  out  1  Avalon strobes, never both high.
- waitrequest  in  1  slave stall.
- writedata  out  DATA_W  lane-shifted store data.
- byteenable  out  BE_W  active lanes.
- readdata  in  DATA_W  valid on the edge where read=1 and waitrequest=0.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. On accept, latch request fields. Legal and aligned -> BUS. Misaligned (half with addr[0]≠0, word with addr[1:0]≠0, dword with addr[2:0]≠0) or size 3 with DATA_W=32 -> RESP with rsp_err=1; no bus cycle issued.
- BUS: read or write held high; address, byteenable and writedata stable. On an edge with waitrequest=0: capture readdata (loads) -> RESP.
- RESP: rsp_valid=1 for exactly one cycle -> IDLE.
- Lane offset o = req_addr[log2(BE_W)-1:0]. byteenable = (1, 3, 0xF, 0xFF for size 0..3) << o. writedata = req_wdata << (8*o); unused lanes are 0.
- Load data = readdata >> (8*o), truncated to 8/16/32/64 bits, then zero-extended, or sign-extended when req_signed=1, to DATA_W.
- Request inputs are ignored outside IDLE.

## Timing
- Reset values: req_ready=1, busy=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, read=0, write=0, address=0, writedata=0, byteenable=0; state IDLE.
- Accept at edge E0; strobe high from E0 to the edge Ew where waitrequest=0 (Ew=E1 when there is no stall); rsp_valid high from Ew to Ew+1. Minimum: 3 cycles per request, 2 cycles request-to-response.
- Error without bus cycle: rsp_valid high in the cycle after E0.
- Each stall cycle adds exactly one cycle of latency.
- Reset during BUS drops read/write asynchronously. The transaction is abandoned and no rsp_valid is issued.

## Configuration
- MIPS_BUS_TIMEOUT_EN defined: a counter clears on entry to BUS and increments on every edge in BUS with waitrequest=1. When it reaches TIMEOUT_CYCLES, the block deasserts read/write, moves to RESP with rsp_err=1 and rsp_rdata=0.
- MIPS_BUS_TIMEOUT_EN undefined: no counter; BUS waits indefinitely; TIMEOUT_CYCLES is unused.

## Test plan
- Word load, addr 0x100, readdata 0xDEADBEEF, no stall -> byteenable 0xF, address 0x100, rsp_valid 2 cycles after accept, rsp_rdata 0xDEADBEEF, rsp_err 0.
- Signed byte load, addr 0x103, readdata 0x80000000 -> byteenable 0x8, address 0x100, rsp_rdata 0xFFFFFF80; unsigned gives 0x00000080.
- Half store, addr 0x202, wdata 0x1234, 3 stall cycles -> write held 4 cycles, byteenable 0xC, writedata 0x12340000, rsp_valid 5 cycles after accept.
- Word load, addr 0x101 -> read never asserted, rsp_valid+rsp_err the next cycle; size 3 with DATA_W=32 -> same result.
- DATA_W=64, dword load, addr 0x08, readdata 0x0123456789ABCDEF -> byteenable 0xFF, rsp_rdata equal to readdata.
- MIPS_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck high -> read drops after 4 stall edges, rsp_err=1. Separately: reset asserted mid-BUS -> read=0 immediately, no rsp_valid.

Source files
------------

// File: rtl/mips_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : mips_bus_master
// Purpose  : Avalon-MM bus master for the multi-cycle MIPS core. Takes one
//            load/store at a time, drives an aligned address, byteenable and
//            lane-shifted writedata, waits out waitrequest stalls and returns
//            zero/sign-extended load data with a one-cycle response pulse.
//            Misaligned accesses and illegal sizes complete with rsp_err and
//            never touch the bus.
// Options  : define MIPS_BUS_TIMEOUT_EN to abort a bus cycle that stays
//            stalled for TIMEOUT_CYCLES edges (completes with rsp_err).
// Revision : 1.0 - initial release
// ============================================================================
module mips_bus_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  // core request / response
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                busy,
  // Avalon-MM master
  output logic [ADDR_W-1:0]   address,
  output logic                read,
  output logic                write,
  input  logic                waitrequest,
  output logic [DATA_W-1:0]   writedata,
  output logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Lanes covered by an access of 2**size bytes starting at lane 0.
  function automatic logic [BE_W-1:0] size_lanes(input logic [1:0] size);
    logic [BE_W-1:0] l;
    for (int i = 0; i < BE_W; i++) l[i] = (i < (1 << size));
    return l;
  endfunction

  // Expand a per-lane flag vector into a per-bit mask.
  function automatic logic [DATA_W-1:0] lanes_to_bits(input logic [BE_W-1:0] l);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < BE_W; i++) m[8*i +: 8] = {8{l[i]}};
    return m;
  endfunction

  logic [1:0]        state;
  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [OFF_W-1:0]  off_q;

  logic [OFF_W-1:0]  req_off;
  logic [BE_W-1:0]   req_lanes;
  logic              req_bad;
  logic [BE_W-1:0]   req_be;
  logic [DATA_W-1:0] req_wdata_sh;
  logic [DATA_W-1:0] rd_sh;
  logic [DATA_W-1:0] rd_mask;
  logic              rd_sign;
  logic [DATA_W-1:0] rd_ext;
  logic              timeout_hit;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);

  // Decode the incoming request: legality check, lane enables, shifted data.
  always_comb begin
    req_off   = req_addr[OFF_W-1:0];
    req_lanes = size_lanes(req_size);
    req_bad   = 1'b0;
    case (req_size)
      2'd1:    req_bad = req_addr[0];
      2'd2:    req_bad = |req_addr[1:0];
      2'd3:    req_bad = (|req_addr[2:0]) || (DATA_W != 64);
      default: req_bad = 1'b0;
    endcase
    req_be       = req_lanes << req_off;
    // Bytes above the access size are dropped so unused lanes stay zero.
    req_wdata_sh = (req_wdata & lanes_to_bits(req_lanes)) << {req_off, 3'b000};
  end

  // Align returned data to bit 0, truncate to the access size and extend.
  always_comb begin
    rd_sh   = readdata >> {off_q, 3'b000};
    rd_mask = lanes_to_bits(size_lanes(size_q));
    case (size_q)
      2'd0:    rd_sign = rd_sh[7];
      2'd1:    rd_sign = rd_sh[15];
      2'd2:    rd_sign = rd_sh[31];
      default: rd_sign = rd_sh[DATA_W-1];
    endcase
    rd_ext = (rd_sh & rd_mask) | ((signed_q && rd_sign) ? ~rd_mask : '0);
  end

`ifdef MIPS_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] stall_cnt;

  // Count stalled edges of the current bus cycle; zero whenever not in BUS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         stall_cnt <= '0;
    else if (state != S_BUS)           stall_cnt <= '0;
    else if (waitrequest)              stall_cnt <= stall_cnt + TO_W'(1);
  end

  // The edge that would bring the count to the limit ends the cycle.
  assign timeout_hit = (state == S_BUS) && waitrequest &&
                       (stall_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Main control FSM with registered bus outputs and response fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'd0;
      signed_q   <= 1'b0;
      off_q      <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            size_q    <= req_size;
            signed_q  <= req_signed;
            off_q     <= req_off;
            rsp_rdata <= '0;
            if (req_bad) begin
              rsp_err <= 1'b1;
              state   <= S_RESP;
            end else begin
              rsp_err    <= 1'b0;
              address    <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              byteenable <= req_be;
              writedata  <= req_write ? req_wdata_sh : '0;
              read       <= ~req_write;
              write      <= req_write;
              state      <= S_BUS;
            end
          end
        end
        S_BUS: begin
          if (timeout_hit) begin
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= S_RESP;
          end else if (!waitrequest) begin
            read      <= 1'b0;
            write     <= 1'b0;
            rsp_rdata <= write_q ? '0 : rd_ext;
            state     <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_bus_master
// Purpose  : Directed self-checking bench: a 32-bit instance (TIMEOUT_CYCLES=4)
//            and a 64-bit instance sharing clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_bus_master;

  int total = 0;
  int bad   = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  // 32-bit instance
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, busy, read, write;
  logic [31:0] rsp_rdata, address, writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;

  // 64-bit instance
  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_req_signed = 1'b0;
  logic [1:0]  b_req_size = 2'd0;
  logic [31:0] b_req_addr = '0;
  logic [63:0] b_req_wdata = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_busy, b_read, b_write;
  logic [63:0] b_rsp_rdata, b_writedata;
  logic [31:0] b_address;
  logic [7:0]  b_byteenable;
  logic        b_waitrequest = 1'b0;
  logic [63:0] b_readdata = '0;

  always #5 clk = ~clk;

  mips_bus_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut32 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .address(address), .read(read),
    .write(write), .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata)
  );

  mips_bus_master #(.ADDR_W(32), .DATA_W(64)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy), .address(b_address), .read(b_read),
    .write(b_write), .waitrequest(b_waitrequest), .writedata(b_writedata),
    .byteenable(b_byteenable), .readdata(b_readdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request to the 32-bit instance; returns #1 after accept edge E0.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_busy",      {63'd0, busy}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_err",   {63'd0, rsp_err}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rst_rd_wr",     {62'd0, read, write}, 64'd0);
    chk("rst_address",   {32'd0, address}, 64'd0);
    chk("rst_writedata", {32'd0, writedata}, 64'd0);
    chk("rst_be",        {60'd0, byteenable}, 64'd0);
    @(negedge clk); reset = 1'b0;

    // ---------------- word load, no stall ----------------
    waitrequest = 1'b0; readdata = 32'hDEADBEEF;
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    chk("lw_read",    {63'd0, read}, 64'd1);
    chk("lw_write",   {63'd0, write}, 64'd0);
    chk("lw_addr",    {32'd0, address}, 64'h100);
    chk("lw_be",      {60'd0, byteenable}, 64'hF);
    chk("lw_busy",    {63'd0, busy}, 64'd1);
    chk("lw_nv_e0",   {63'd0, rsp_valid}, 64'd0);
    tick();
    chk("lw_valid",   {63'd0, rsp_valid}, 64'd1);
    chk("lw_rdata",   {32'd0, rsp_rdata}, 64'hDEADBEEF);
    chk("lw_err",     {63'd0, rsp_err}, 64'd0);
    chk("lw_rd_drop", {63'd0, read}, 64'd0);
    tick();
    chk("lw_pulse",   {63'd0, rsp_valid}, 64'd0);
    chk("lw_ready",   {63'd0, req_ready}, 64'd1);

    // ---------------- signed / unsigned byte load ----------------
    readdata = 32'h80000000;
    issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
    chk("lbs_be",   {60'd0, byteenable}, 64'h8);
    chk("lbs_addr", {32'd0, address}, 64'h100);
    tick();
    chk("lbs_rdata", {32'd0, rsp_rdata}, 64'hFFFFFF80);
    tick();
    issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    tick();
    chk("lbu_rdata", {32'd0, rsp_rdata}, 64'h00000080);
    tick();

    // ---------------- half loads ----------------
    readdata = 32'h80010000;
    issue(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
    chk("lhs_be", {60'd0, byteenable}, 64'hC);
    tick();
    chk("lhs_rdata", {32'd0, rsp_rdata}, 64'hFFFF8001);
    tick();
    readdata = 32'h1234ABCD;
    issue(1'b0, 2'd1, 1'b0, 32'h100, 32'h0);
    tick();
    chk("lhu_rdata", {32'd0, rsp_rdata}, 64'h0000ABCD);
    tick();

    // ---------------- half store with 3 stall cycles ----------------
    waitrequest = 1'b1;
    issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h1234);
    chk("sh_write", {63'd0, write}, 64'd1);
    chk("sh_read",  {63'd0, read}, 64'd0);
    chk("sh_be",    {60'd0, byteenable}, 64'hC);
    chk("sh_wdata", {32'd0, writedata}, 64'h12340000);
    chk("sh_addr",  {32'd0, address}, 64'h200);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("sh_hold",   {63'd0, write}, 64'd1);
      chk("sh_nvalid", {63'd0, rsp_valid}, 64'd0);
    end
    waitrequest = 1'b0;
    tick();
    chk("sh_drop",  {63'd0, write}, 64'd0);
    chk("sh_valid", {63'd0, rsp_valid}, 64'd1);
    chk("sh_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("sh_err",   {63'd0, rsp_err}, 64'd0);
    tick();

    // ---------------- byte store ----------------
    issue(1'b1, 2'd0, 1'b0, 32'h201, 32'hA5A5A555);
    chk("sb_be",    {60'd0, byteenable}, 64'h2);
    chk("sb_wdata", {32'd0, writedata}, 64'h00005500);
    tick(); tick();

    // ---------------- misaligned word / illegal dword ----------------
    readdata = 32'h11111111;
    issue(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    chk("mis_read",  {63'd0, read}, 64'd0);
    chk("mis_valid", {63'd0, rsp_valid}, 64'd1);
    chk("mis_err",   {63'd0, rsp_err}, 64'd1);
    chk("mis_rdata", {32'd0, rsp_rdata}, 64'd0);
    tick();
    chk("mis_pulse", {63'd0, rsp_valid}, 64'd0);
    issue(1'b0, 2'd3, 1'b0, 32'h108, 32'h0);
    chk("dw32_read",  {63'd0, read}, 64'd0);
    chk("dw32_valid", {63'd0, rsp_valid}, 64'd1);
    chk("dw32_err",   {63'd0, rsp_err}, 64'd1);
    tick();

`ifdef MIPS_BUS_TIMEOUT_EN
    // ---------------- stall timeout ----------------
    waitrequest = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("to_hold", {63'd0, read}, 64'd1);
    end
    tick();
    chk("to_drop",  {63'd0, read}, 64'd0);
    chk("to_valid", {63'd0, rsp_valid}, 64'd1);
    chk("to_err",   {63'd0, rsp_err}, 64'd1);
    chk("to_rdata", {32'd0, rsp_rdata}, 64'd0);
    waitrequest = 1'b0;
    tick();
`endif

    // ---------------- reset mid-BUS ----------------
    waitrequest = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    chk("rb_read", {63'd0, read}, 64'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rb_read_drop", {63'd0, read}, 64'd0);
    chk("rb_busy",      {63'd0, busy}, 64'd0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rb_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end

    // ---------------- 64-bit instance ----------------
    b_readdata = 64'h0123456789ABCDEF;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_size = 2'd3;
    b_req_signed = 1'b0; b_req_addr = 32'h08;
    tick();
    b_req_valid = 1'b0;
    chk("ld64_be",   {56'd0, b_byteenable}, 64'hFF);
    chk("ld64_addr", {32'd0, b_address}, 64'h08);
    tick();
    chk("ld64_valid", {63'd0, b_rsp_valid}, 64'd1);
    chk("ld64_rdata", b_rsp_rdata, 64'h0123456789ABCDEF);
    chk("ld64_err",   {63'd0, b_rsp_err}, 64'd0);
    tick();
    @(negedge clk);
    b_req_valid = 1'b1; b_req_size = 2'd2; b_req_addr = 32'h0C;
    tick();
    b_req_valid = 1'b0;
    chk("lw64_be",   {56'd0, b_byteenable}, 64'hF0);
    chk("lw64_addr", {32'd0, b_address}, 64'h08);
    tick();
    chk("lw64_rdata", b_rsp_rdata, 64'h0000000001234567);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
